// File: rtl/test_card_gradient_anim.sv
// Gradient test-card generator: ramp from x or y plus per-channel base, with per-frame scroll.
// Latency 2 cycles from coordinates/de to colours; no backpressure, one pixel per clock.
module test_card_gradient_anim #(
  parameter int                 STEP      = 2,
  parameter int                 COLOR_W   = 8,
  parameter int                 COORD_W   = 16,
  parameter logic [COLOR_W-1:0] BASE_R    = 8'h00,
  parameter logic [COLOR_W-1:0] BASE_G    = 8'h10,
  parameter logic [COLOR_W-1:0] BASE_B    = 8'h4C,
  parameter int                 MODE      = 0,
  parameter int                 SAT       = 0,
  parameter int                 ANIM_RATE = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_de,
  input  logic               i_frame,
  input  logic               i_anim_en,
  input  logic               i_anim_clr,
  output logic [COLOR_W-1:0] o_red,
  output logic [COLOR_W-1:0] o_green,
  output logic [COLOR_W-1:0] o_blue,
  output logic               o_de,
  output logic [COLOR_W-1:0] o_offset
);

  localparam int FW = (ANIM_RATE > 1) ? $clog2(ANIM_RATE) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(ANIM_RATE - 1);

  logic [FW-1:0]      fcnt;
  logic [COLOR_W-1:0] offset;
  logic [COLOR_W-1:0] ramp_s1;
  logic               de_s1;
  logic [COORD_W-1:0] coord;

  assign coord    = (MODE != 0) ? i_x : i_y;
  assign o_offset = offset;

  function automatic logic [COLOR_W-1:0] chan(input logic [COLOR_W-1:0] base,
                                              input logic [COLOR_W-1:0] r);
    logic [COLOR_W:0] s;
    s = {1'b0, base} + {1'b0, r};
    if ((SAT != 0) && s[COLOR_W]) chan = '1;
    else                          chan = s[COLOR_W-1:0];
  endfunction

  // Clear beats a coincident frame pulse; a disabled animation freezes in place.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fcnt   <= '0;
      offset <= '0;
    end else if (i_anim_clr) begin
      fcnt   <= '0;
      offset <= '0;
    end else if (i_frame && i_anim_en) begin
      if (fcnt == FCNT_LAST) begin
        fcnt   <= '0;
        offset <= offset + 1'b1;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ramp_s1 <= '0;
      de_s1   <= 1'b0;
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
      o_de    <= 1'b0;
    end else begin
      ramp_s1 <= coord[COLOR_W+STEP-1:STEP] + offset;
      de_s1   <= i_de;
      o_de    <= de_s1;
      if (de_s1) begin
        o_red   <= chan(BASE_R, ramp_s1);
        o_green <= chan(BASE_G, ramp_s1);
        o_blue  <= chan(BASE_B, ramp_s1);
      end else begin
        o_red   <= '0;
        o_green <= '0;
        o_blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_test_card_gradient_anim.sv
// Directed bench: default, saturating and horizontal instances share one stimulus set.
module tb_test_card_gradient_anim;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [15:0] i_x = '0;
  logic [15:0] i_y = '0;
  logic        i_de = 1'b0;
  logic        i_frame = 1'b0;
  logic        i_anim_en = 1'b0;
  logic        i_anim_clr = 1'b0;

  logic [7:0] r0, g0, b0, off0, r1, g1, b1, off1, r2, g2, b2, off2;
  logic       de0, de1, de2;

  int total = 0;
  int bad = 0;

  always #5 i_clk = ~i_clk;

  test_card_gradient_anim u_def (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_x(i_x), .i_y(i_y), .i_de(i_de),
    .i_frame(i_frame), .i_anim_en(i_anim_en), .i_anim_clr(i_anim_clr),
    .o_red(r0), .o_green(g0), .o_blue(b0), .o_de(de0), .o_offset(off0));

  test_card_gradient_anim #(.SAT(1)) u_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_x(i_x), .i_y(i_y), .i_de(i_de),
    .i_frame(i_frame), .i_anim_en(i_anim_en), .i_anim_clr(i_anim_clr),
    .o_red(r1), .o_green(g1), .o_blue(b1), .o_de(de1), .o_offset(off1));

  test_card_gradient_anim #(.MODE(1)) u_hor (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_x(i_x), .i_y(i_y), .i_de(i_de),
    .i_frame(i_frame), .i_anim_en(i_anim_en), .i_anim_clr(i_anim_clr),
    .o_red(r2), .o_green(g2), .o_blue(b2), .o_de(de2), .o_offset(off2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic pulse(input int n);
    for (int k = 0; k < n; k++) begin
      i_frame = 1'b1;
      tick();
      i_frame = 1'b0;
      tick();
    end
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_red", r0, 8'h00);
    chk("rst_blue", b0, 8'h00);
    chk("rst_de", de0, 1'b0);
    chk("rst_off", off0, 8'h00);
    tick();
    i_rst_n = 1'b1;
    tick(2);

    // basic ramp, latency 2
    i_y = 16'd100; i_de = 1'b1;
    tick();
    chk("lat1_red", r0, 8'h00);
    chk("lat1_de", de0, 1'b0);
    tick();
    chk("y100_red", r0, 8'h19);
    chk("y100_green", g0, 8'h29);
    chk("y100_blue", b0, 8'h65);
    chk("y100_de", de0, 1'b1);

    // overflow: wrap vs saturate
    i_y = 16'd1020;
    tick(2);
    chk("wrap_red", r0, 8'hFF);
    chk("wrap_green", g0, 8'h0F);
    chk("wrap_blue", b0, 8'h4B);
    chk("sat_red", r1, 8'hFF);
    chk("sat_green", g1, 8'hFF);
    chk("sat_blue", b1, 8'hFF);

    // animation
    i_anim_en = 1'b1;
    pulse(3);
    chk("off_3p", off0, 8'h00);
    pulse(1);
    chk("off_4p", off0, 8'h01);
    i_y = 16'd0;
    tick(2);
    chk("anim_red", r0, 8'h01);
    chk("anim_blue", b0, 8'h4D);
    i_anim_en = 1'b0;
    pulse(5);
    chk("off_frozen", off0, 8'h01);
    i_anim_en = 1'b1;
    pulse(3);
    chk("off_resume_hold", off0, 8'h01);
    // frame-cycle pixel uses old offset, next pixel the new one
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    tick();
    chk("old_off_pix", r0, 8'h01);
    tick();
    chk("new_off_pix", r0, 8'h02);
    pulse(1016);
    chk("off_wrap", off0, 8'h00);

    // clear beats frame with fcnt=3
    pulse(4);
    pulse(3);
    chk("off_pre_clr", off0, 8'h01);
    i_frame = 1'b1; i_anim_clr = 1'b1;
    tick();
    i_frame = 1'b0; i_anim_clr = 1'b0;
    chk("off_clr", off0, 8'h00);
    pulse(3);
    chk("fcnt_clr_3p", off0, 8'h00);
    pulse(1);
    chk("fcnt_clr_4p", off0, 8'h01);
    i_anim_clr = 1'b1;
    tick();
    i_anim_clr = 1'b0;

    // blanking for 3 cycles
    i_de = 1'b0; i_y = 16'd200;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) i_de = 1'b1;
      chk("blank_red", r0, 8'h00);
      chk("blank_green", g0, 8'h00);
      chk("blank_blue", b0, 8'h00);
      chk("blank_de", de0, 1'b0);
      tick();
    end
    chk("unblank_red", r0, 8'h32);
    chk("unblank_de", de0, 1'b1);

    // horizontal axis
    i_x = 16'd40; i_y = 16'd1000;
    tick(2);
    chk("hor_red", r2, 8'h0A);
    chk("vert_red", r0, 8'hFA);

    // async reset mid-line, then recovery
    pulse(4);
    chk("off_before_rst", off0, 8'h01);
    i_y = 16'd100;
    tick(2);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_red", r0, 8'h00);
    chk("arst_blue", b0, 8'h00);
    chk("arst_de", de0, 1'b0);
    chk("arst_off", off0, 8'h00);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("post_rst_lat_de", de0, 1'b0);
    tick();
    chk("post_rst_red", r0, 8'h19);
    chk("post_rst_de", de0, 1'b1);
    chk("post_rst_off", off0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
